// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, sweep FSM state type and MIPS register names
package regfile_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} rf_state_t;
  localparam logic [4:0] ZERO = 5'd0;
  localparam logic [4:0] T0 = 5'd8, T1 = 5'd9, T2 = 5'd10, T3 = 5'd11;
  localparam logic [4:0] T4 = 5'd12, T5 = 5'd13, T6 = 5'd14, T7 = 5'd15;
  localparam logic [4:0] S0 = 5'd16, S1 = 5'd17, S2 = 5'd18, S3 = 5'd19;
  localparam logic [4:0] S4 = 5'd20, S5 = 5'd21, S6 = 5'd22, S7 = 5'd23;
  localparam logic [4:0] RA = 5'd31;
endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: post-reset sweep that zeroes one entry per cycle
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);
  rf_state_t         r_state;
  logic [ADDR_W-1:0] r_ptr;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
    end else if (r_state == CLEAR) begin
      if (&r_ptr) r_state <= RUN;
      else r_ptr <= r_ptr + 1'b1;
    end
  end
  assign clr_we   = r_state == CLEAR;
  assign clr_addr = r_ptr;
  assign ready    = r_state == RUN;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with prioritised dual write, bypass and zero register
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] r_addr,
  output logic [NUM_RD*WIDTH-1:0]  r_data,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        w_addr0,
  input  logic [WIDTH-1:0]         w_data0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        w_addr1,
  input  logic [WIDTH-1:0]         w_data1,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_we0;
  logic              w_we1;
  regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
    .clk      (clk),
    .reset    (reset),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr),
    .ready    (ready)
  );
  // port 1 wins a same-address collision; address 0 is never stored
  assign w_we1 = ready && we1 && w_addr1 != '0;
  assign w_we0 = ready && we0 && w_addr0 != '0 && !(we1 && w_addr1 == w_addr0);
  always_ff @(posedge clk) begin
    if (w_clr_we) r_mem[w_clr_addr] <= '0;
    else begin
      if (w_we0) r_mem[w_addr0] <= w_data0;
      if (w_we1) r_mem[w_addr1] <= w_data1;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    assign w_a = r_addr[k*ADDR_W +: ADDR_W];
    assign r_data[k*WIDTH +: WIDTH] =
      (!ready || w_a == '0)               ? '0      :
      (BYPASS && we1 && w_addr1 == w_a)   ? w_data1 :
      (BYPASS && we0 && w_addr0 == w_a)   ? w_data0 : r_mem[w_a];
  end
  assign dbg_data = (!ready || dbg_addr == '0) ? '0 : r_mem[dbg_addr];
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed plan plus random traffic against a behavioural register-file model
module tb_regfile_mp;
  import regfile_pkg::*;
  localparam int W = 32, A = 5, D = 32;
  logic clk = 1'b0, reset = 1'b1;
  logic [2*A-1:0] r_addr = '0;
  logic we0 = 1'b0, we1 = 1'b0;
  logic [A-1:0] w_addr0 = '0, w_addr1 = '0, dbg_addr = '0;
  logic [W-1:0] w_data0 = '0, w_data1 = '0;
  logic ready_b, ready_n;
  logic [2*W-1:0] rd_b, rd_n;
  logic [W-1:0] dbg_b, dbg_n;
  logic [W-1:0] mem_m [D];
  int clr_left = D;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  regfile_mp #(.WIDTH(W), .ADDR_W(A), .NUM_RD(2), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .ready(ready_b), .r_addr(r_addr), .r_data(rd_b),
    .we0(we0), .w_addr0(w_addr0), .w_data0(w_data0),
    .we1(we1), .w_addr1(w_addr1), .w_data1(w_data1),
    .dbg_addr(dbg_addr), .dbg_data(dbg_b));
  regfile_mp #(.WIDTH(W), .ADDR_W(A), .NUM_RD(2), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .ready(ready_n), .r_addr(r_addr), .r_data(rd_n),
    .we0(we0), .w_addr0(w_addr0), .w_data0(w_data0),
    .we1(we1), .w_addr1(w_addr1), .w_data1(w_data1),
    .dbg_addr(dbg_addr), .dbg_data(dbg_n));
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [W-1:0] exp_rd(input logic [A-1:0] a, input bit byp);
    if (clr_left != 0 || a == 0) return '0;
    if (byp && we1 && w_addr1 == a) return w_data1;
    if (byp && we0 && w_addr0 == a) return w_data0;
    return mem_m[a];
  endfunction
  task automatic check_all();
    chk("ready_b", W'(ready_b), W'(clr_left == 0));
    chk("ready_n", W'(ready_n), W'(clr_left == 0));
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rd_b%0d", k), rd_b[k*W +: W], exp_rd(r_addr[k*A +: A], 1'b1));
      chk($sformatf("rd_n%0d", k), rd_n[k*W +: W], exp_rd(r_addr[k*A +: A], 1'b0));
    end
    chk("dbg_b", dbg_b, exp_rd(dbg_addr, 1'b0));
    chk("dbg_n", dbg_n, exp_rd(dbg_addr, 1'b0));
  endtask
  task automatic settle();
    #4;
    check_all();
  endtask
  task automatic tick();
    @(posedge clk);
    if (clr_left == 0) begin
      if (we0 && w_addr0 != 0 && !(we1 && w_addr1 == w_addr0)) mem_m[w_addr0] = w_data0;
      if (we1 && w_addr1 != 0) mem_m[w_addr1] = w_data1;
    end
    if (reset) begin
      foreach (mem_m[i]) mem_m[i] = '0;
      clr_left = D;
    end else if (clr_left > 0) clr_left--;
    #1;
  endtask
  task automatic idle();
    we0 = 1'b0; we1 = 1'b0;
  endtask
  initial begin
    int n;
    foreach (mem_m[i]) mem_m[i] = '0;
    tick();
    reset = 1'b0;
    we0 = 1'b1; w_addr0 = T0; w_data0 = 32'hDEADBEEF; r_addr = {T0, T0};
    for (int i = 0; i < D; i++) begin
      chk("clear_ready", W'(ready_b), '0);
      settle();
      tick();
    end
    idle();
    chk("ready_up", W'(ready_b), W'(1));
    settle();
    chk("t0_dropped", rd_b[0 +: W], '0);
    for (int i = 0; i < D; i++) begin
      dbg_addr = A'(i);
      settle();
      chk($sformatf("swept%0d", i), dbg_b, '0);
      tick();
    end
    we0 = 1'b1; w_addr0 = T1; w_data0 = 32'h12345678;
    settle(); tick();
    idle(); r_addr = {T1, ZERO};
    settle();
    chk("wr_rd", rd_b[W +: W], 32'h12345678);
    tick();
    we0 = 1'b1; w_addr0 = T2; w_data0 = 32'hAAAA0000;
    we1 = 1'b1; w_addr1 = T2; w_data1 = 32'h0000BBBB;
    r_addr = {ZERO, T2}; dbg_addr = T2;
    settle();
    chk("byp_prio", rd_b[0 +: W], 32'h0000BBBB);
    chk("dbg_old", dbg_b, '0);
    tick();
    idle();
    settle();
    chk("prio_commit", rd_b[0 +: W], 32'h0000BBBB);
    tick();
    we0 = 1'b1; w_addr0 = ZERO; w_data0 = '1;
    we1 = 1'b1; w_addr1 = ZERO; w_data1 = '1;
    r_addr = {ZERO, ZERO}; dbg_addr = ZERO;
    settle();
    chk("zero_same", rd_b, '0);
    tick();
    idle();
    settle();
    chk("zero_after0", rd_b, '0);
    chk("zero_dbg", dbg_b, '0);
    tick();
    we0 = 1'b1; w_addr0 = S4; w_data0 = 32'h55; r_addr = {ZERO, S4};
    settle();
    chk("nb_old", rd_n[0 +: W], '0);
    chk("b_new", rd_b[0 +: W], 32'h55);
    tick();
    idle();
    settle();
    chk("nb_new", rd_n[0 +: W], 32'h55);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      settle(); tick();
    end
    reset = 1'b1; settle(); tick(); reset = 1'b0;
    n = 0;
    while (!ready_b && n < 100) begin
      settle(); tick(); n++;
    end
    chk("sweep_len", W'(n), W'(32));
    for (int i = 0; i < 400; i++) begin
      reset = $urandom_range(0, 99) == 0;
      we0 = 1'($urandom); we1 = 1'($urandom);
      w_addr0 = A'($urandom_range(0, 7));
      w_addr1 = $urandom_range(0, 3) == 0 ? w_addr0 : A'($urandom_range(0, 7));
      w_data0 = $urandom; w_data1 = $urandom;
      r_addr = {($urandom_range(0, 1) == 0 ? w_addr1 : A'($urandom_range(0, 7))),
                ($urandom_range(0, 1) == 0 ? w_addr0 : A'($urandom_range(0, 7)))};
      dbg_addr = A'($urandom_range(0, 7));
      settle();
      tick();
    end
    reset = 1'b0; idle();
    n = 0;
    while (!ready_b && n < 100) begin
      settle(); tick(); n++;
    end
    chk("final_ready", W'(ready_b), W'(1));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
